clk_enable_gen: RTL and testbench

- Multi-channel clock-enable generator. Successor to the fixed divide-by-4 pixel-clock pulse generator.
- Each channel divides the system clock by a runtime-programmable ratio. Each channel gives two outputs:
  - a single-cycle tick (clock enable);
  - a near-50% square enable, used to drive camera XCLK-style outputs and pixel-rate pipelines.
- A global sync re-phases all enabled channels together.
- Sits beside the camera driver and the VGA/pixel pipelines. Replaces ad-hoc per-module dividers.

---
 rtl/clk_enable_gen.sv | 108 ++++++++++
 tb/tb_clk_enable_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divider giving
// a one-cycle tick and a near-50% square enable, with a shared phase-align sync.
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       sq_o,
  output logic [NUM_CH-1:0]       div_busy_o
);

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV =
    (DEFAULT_DIV < 2) ? MIN_DIV : DIV_W'(DEFAULT_DIV);

  // Divisors below 2 cannot produce a distinct tick, so they run as 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] load_val;
    logic             wrap;
    logic             half;

    assign load_val = clamp_div(div_val[i*DIV_W +: DIV_W]);
    assign wrap     = (cnt_q == n_q - DIV_W'(1));
    assign half     = (cnt_q == (n_q >> 1) - DIV_W'(1));

    // Next-state: disable > sync > wrap > count; new divisors only take effect
    // at a period boundary so no runt pulse is ever produced.
    always_comb begin
      cnt_d  = cnt_q;
      n_d    = n_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      busy_d = busy_q;
      if (!ch_en[i]) begin
        cnt_d  = '0;
        sq_d   = 1'b0;
        busy_d = 1'b0;
        if (div_load[i]) begin
          n_d = load_val;
        end else if (busy_q) begin
          n_d = pend_q;
        end
      end else begin
        if (sync) begin
          cnt_d  = '0;
          sq_d   = 1'b0;
          busy_d = 1'b0;
          if (busy_q) n_d = pend_q;
        end else if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = 1'b1;
          busy_d = 1'b0;
          if (busy_q) n_d = pend_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (half) sq_d = 1'b0;
        end
        // A load on a boundary edge lands in pending for the following period.
        if (div_load[i]) begin
          pend_d = load_val;
          busy_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        n_q    <= RST_DIV;
        pend_q <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        n_q    <= n_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
        busy_q <= busy_d;
      end
    end

    assign tick_o[i]     = tick_q;
    assign sq_o[i]       = sq_q;
    assign div_busy_o[i] = busy_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: period-level reference model checked every cycle,
// plus directed sequences with hand-computed tick spacings and levels.
module tb_clk_enable_gen;
  localparam int NUM_CH = 2;
  localparam int DW     = 8;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*DW-1:0] div_val;
  logic [NUM_CH-1:0]    div_load;
  logic                 sync;
  logic [NUM_CH-1:0]    tick_o;
  logic [NUM_CH-1:0]    sq_o;
  logic [NUM_CH-1:0]    div_busy_o;

  int checks = 0;
  int errors = 0;

  clk_enable_gen #(.NUM_CH(NUM_CH), .DIV_W(DW), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .div_val(div_val),
    .div_load(div_load), .sync(sync), .tick_o(tick_o), .sq_o(sq_o),
    .div_busy_o(div_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each channel tracks edges counted into the current period (ph),
  // whether a period has completed since (re)start, its divisor and pending load.
  int m_n    [NUM_CH] = '{default: 4};
  int m_pend [NUM_CH] = '{default: 0};
  int m_busy [NUM_CH] = '{default: 0};
  int m_ph   [NUM_CH] = '{default: 0};
  int m_wr   [NUM_CH] = '{default: 0};

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_n[i] = 4; m_pend[i] = 0; m_busy[i] = 0; m_ph[i] = 0; m_wr[i] = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int v;
        v = clampv(int'(div_val[i*DW +: DW]));
        if (!ch_en[i]) begin
          m_ph[i] = 0; m_wr[i] = 0;
          if (div_load[i]) m_n[i] = v;
          else if (m_busy[i] != 0) m_n[i] = m_pend[i];
          m_busy[i] = 0;
        end else if (sync) begin
          m_ph[i] = 0; m_wr[i] = 0;
          if (m_busy[i] != 0) m_n[i] = m_pend[i];
          m_busy[i] = 0;
          if (div_load[i]) begin m_pend[i] = v; m_busy[i] = 1; end
        end else if (m_ph[i] + 1 == m_n[i]) begin
          m_ph[i] = 0; m_wr[i] = 1;
          if (m_busy[i] != 0) m_n[i] = m_pend[i];
          m_busy[i] = div_load[i] ? 1 : 0;
          if (div_load[i]) m_pend[i] = v;
        end else begin
          m_ph[i] = m_ph[i] + 1;
          if (div_load[i]) begin m_pend[i] = v; m_busy[i] = 1; end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      int e_tick, e_sq;
      e_tick = (m_wr[i] != 0 && m_ph[i] == 0) ? 1 : 0;
      e_sq   = (m_wr[i] != 0 && m_ph[i] < m_n[i] / 2) ? 1 : 0;
      checks += 3;
      if (int'(tick_o[i]) != e_tick) begin
        errors++;
        $display("FAIL model_tick ch%0d t=%0t: got %0d expected %0d", i, $time, tick_o[i], e_tick);
      end
      if (int'(sq_o[i]) != e_sq) begin
        errors++;
        $display("FAIL model_sq ch%0d t=%0t: got %0d expected %0d", i, $time, sq_o[i], e_sq);
      end
      if (int'(div_busy_o[i]) != m_busy[i]) begin
        errors++;
        $display("FAIL model_busy ch%0d t=%0t: got %0d expected %0d", i, $time, div_busy_o[i], m_busy[i]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Counts falling edges until tick_o[ch] is seen high; bounded.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n++;
      if (tick_o[ch]) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_tick ch%0d: no tick within 40 cycles", ch);
    n = -1;
  endtask

  task automatic pulse_load(input int ch, input int v);
    div_val[ch*DW +: DW] = DW'(v);
    div_load[ch] = 1'b1;
    @(negedge clk);
    div_load = '0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ch_en = '0; div_val = '0; div_load = '0; sync = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tick", int'(tick_o), 0);
    check("rst_sq", int'(sq_o), 0);
    check("rst_busy", int'(div_busy_o), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Default divide-by-4 after enable.
    ch_en = 2'b01;
    wait_tick(0, n); check("first_tick_latency", n, 4);
    check("first_tick_sq", int'(sq_o[0]), 1);
    wait_tick(0, n); check("period_4", n, 4);
    @(negedge clk); check("sq4_second_high", int'(sq_o[0]), 1);
    @(negedge clk); check("sq4_low", int'(sq_o[0]), 0);

    // Mid-period load of 5 waits for the current wrap.
    pulse_load(0, 5);
    check("busy_after_load5", int'(div_busy_o[0]), 1);
    wait_tick(0, n); check("old_period_completes", n, 1);
    check("busy_clear_at_wrap", int'(div_busy_o[0]), 0);
    wait_tick(0, n); check("period_5", n, 5);
    @(negedge clk); check("sq5_second_high", int'(sq_o[0]), 1);
    @(negedge clk); check("sq5_low", int'(sq_o[0]), 0);
    wait_tick(0, n); check("period_5_again", n, 3);

    // Load 0 clamps to 2; then load 1 on a wrap edge stays pending one period.
    pulse_load(0, 0);
    check("busy_after_load0", int'(div_busy_o[0]), 1);
    wait_tick(0, n); check("finish_period5", n, 4);
    wait_tick(0, n); check("period_2_from_0", n, 2);
    @(negedge clk); check("sq2_low", int'(sq_o[0]), 0);
    pulse_load(0, 1);
    check("tick_on_load_edge", int'(tick_o[0]), 1);
    check("busy_load_on_wrap", int'(div_busy_o[0]), 1);
    wait_tick(0, n); check("period_2_pending1", n, 2);
    check("busy_clear_load1", int'(div_busy_o[0]), 0);
    wait_tick(0, n); check("period_2_from_1", n, 2);

    // Ch1 = 6 loaded while disabled, ch0 back to 4, then global sync.
    div_val = {8'd6, 8'd4};
    div_load = 2'b11;
    @(negedge clk);
    div_load = '0;
    ch_en = 2'b11;
    repeat (7) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_tick_zero", int'(tick_o), 0);
    check("sync_sq_zero", int'(sq_o), 0);
    check("sync_busy_zero", int'(div_busy_o), 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("sync_ticks_k%0d", k), int'(tick_o), int'({k % 6 == 0, k % 4 == 0}));
    end

    // Disable with a pending load of 3.
    pulse_load(0, 3);
    check("busy_pending3", int'(div_busy_o[0]), 1);
    check("sq_high_before_disable", int'(sq_o[0]), 1);
    ch_en = 2'b10;
    @(negedge clk);
    check("dis_tick", int'(tick_o[0]), 0);
    check("dis_sq", int'(sq_o[0]), 0);
    check("dis_busy", int'(div_busy_o[0]), 0);
    @(negedge clk);
    ch_en = 2'b11;
    wait_tick(0, n); check("reenable_period_3", n, 3);

    // Asynchronous reset with sq high, away from any clock edge.
    check("sq_high_before_reset", int'(sq_o[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_tick", int'(tick_o), 0);
    check("async_rst_sq", int'(sq_o), 0);
    check("async_rst_busy", int'(div_busy_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick(0, n); check("post_reset_default_div", n, 4);
    check("post_reset_ch1_tick", int'(tick_o[1]), 1);
    wait_tick(0, n); check("post_reset_period", n, 4);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
